// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative, handshaked AES MixColumns engine.
// Processes COLS_PER_CYCLE columns per busy cycle (1, 2 or 4).
// Optional feature macro: MIXCOL_INV_EN builds the InvMixColumns datapath and
// the mode flag; without it in_inv is ignored and only MixColumns is built.
module mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] Step    = 2'(COLS_PER_CYCLE);
    // col_cnt value at the start of the cycle that handles column 3
    localparam logic [1:0] LastCnt = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [127:0] res_q, res_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [1:0]   col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a[4];
        logic [7:0] t[4];
        for (int i = 0; i < 4; i++) begin
            a[i] = c[8*i +: 8];
            t[i] = xtime(a[i]);
        end
        return {t[0] ^ a[0] ^ a[1] ^ a[2] ^ t[3],
                a[0] ^ a[1] ^ t[2] ^ t[3] ^ a[3],
                a[0] ^ t[1] ^ t[2] ^ a[2] ^ a[3],
                t[0] ^ t[1] ^ a[1] ^ a[2] ^ a[3]};
    endfunction

`ifdef MIXCOL_INV_EN
    logic mode_q, mode_d;

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a[4];
        logic [7:0] m9[4];
        logic [7:0] mb[4];
        logic [7:0] md[4];
        logic [7:0] me[4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[8*i +: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {mb[0] ^ md[1] ^ m9[2] ^ me[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                me[0] ^ mb[1] ^ md[2] ^ m9[3]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        return inv ? mix_inv(c) : mix_fwd(c);
    endfunction

    // Mode flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 1'b0;
        else        mode_q <= mode_d;
    end

    // Mode flag captured only on acceptance
    always_comb begin
        mode_d = mode_q;
        if (state_q == StIdle && in_valid) mode_d = in_inv;
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
        logic unused_inv;
        unused_inv = inv;
        return mix_fwd(c);
    endfunction

    logic mode_q;
    assign mode_q = 1'b0;
`endif

    // State, work, result and column-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            work_q    <= '0;
            res_q     <= '0;
            col_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            res_q     <= res_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    // Next-state logic and per-cycle column transform
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        res_d     = res_q;
        col_cnt_d = col_cnt_q;
        col       = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d    = in_data;
                    col_cnt_d = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
                    col = col_cnt_q + 2'(j);
                    res_d[{col, 5'b0} +: 32] = mix_col(work_q[{col, 5'b0} +: 32], mode_q);
                end
                // Wraps to 0 together with the move to StDone
                col_cnt_d = col_cnt_q + Step;
                if (col_cnt_q == LastCnt) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StBusy);
    assign out_valid = (state_q == StDone);
    assign out_data  = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance per COLS_PER_CYCLE value (1, 2, 4),
// directed vectors followed by randomised round trips against a GF(2^8) model.
module tb_mix_columns_seq;

    localparam logic [127:0] FwdIn  = 128'h4c31262d_01010101_5c220af2_455313db;
    localparam logic [127:0] FwdOut = 128'hf8bd7e4d_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] ColIn  = 128'hd5d4d4d4_c6c6c6c6_01010101_d5d4d4d4;
    localparam logic [127:0] ColFwd = 128'hd6d7d5d5_c6c6c6c6_01010101_d6d7d5d5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid[3];
    logic         in_ready[3];
    logic         in_inv[3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic         busy[3];
    logic [127:0] in_data[3];
    logic [127:0] out_data[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(
            .COLS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference multiply: shift-and-add over GF(2^8)
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   base[4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        base[0] = inv ? 8'h0e : 8'h02;
        base[1] = inv ? 8'h0b : 8'h03;
        base[2] = inv ? 8'h0d : 8'h01;
        base[3] = inv ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gm(base[(j - rr) & 3], s[32*c + 8*j +: 8]);
                r[32*c + 8*rr +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic eff(input logic inv);
`ifdef MIXCOL_INV_EN
        return inv;
`else
        return inv & 1'b0;
`endif
    endfunction

    // One full transaction on instance k, optionally stalling out_ready for gap cycles
    task automatic xfer(input int k, input logic [127:0] d, input logic inv,
                        input logic [127:0] exp, input int gap, input string tag);
        int lat = 0;
        while (!in_ready[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " in_ready_idle"}, 128'(in_ready[k]), 128'd1);
        out_ready[k] = (gap == 0);
        in_valid[k]  = 1'b1;
        in_data[k]   = d;
        in_inv[k]    = inv;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[k]   = ~inv;
        check({tag, " busy_after_accept"}, 128'(busy[k]), 128'd1);
        check({tag, " in_ready_busy"}, 128'(in_ready[k]), 128'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid[k] && lat < 20);
        check({tag, " latency"}, 128'(lat), 128'(4 >> k));
        check({tag, " out_data"}, out_data[k], exp);
        check({tag, " busy_done"}, 128'(busy[k]), 128'd0);
        for (int i = 0; i < gap; i++) begin
            in_valid[k] = 1'b1;
            in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 128'(out_valid[k]), 128'd1);
            check({tag, " hold_in_ready"}, 128'(in_ready[k]), 128'd0);
            check({tag, " hold_data"}, out_data[k], exp);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        check({tag, " out_valid_drop"}, 128'(out_valid[k]), 128'd0);
        check({tag, " in_ready_back"}, 128'(in_ready[k]), 128'd1);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x;
        logic         m;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_inv[k]    = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            check("reset in_ready", 128'(in_ready[k]), 128'd1);
            check("reset out_valid", 128'(out_valid[k]), 128'd0);
            check("reset busy", 128'(busy[k]), 128'd0);
            check("reset out_data", out_data[k], 128'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) xfer(k, FwdIn, 1'b0, FwdOut, 0, "fwd_vector");
`ifdef MIXCOL_INV_EN
        for (int k = 0; k < 3; k++) xfer(k, FwdOut, 1'b1, FwdIn, 0, "inv_vector");
        for (int k = 0; k < 3; k++) xfer(k, ColIn, 1'b1, model(ColIn, 1'b1), 0, "col_inv");
`else
        for (int k = 0; k < 3; k++) xfer(k, ColIn, 1'b1, ColFwd, 0, "col_inv_ignored");
`endif
        for (int k = 0; k < 3; k++) xfer(k, ColIn, 1'b0, ColFwd, 0, "col_fwd");

        xfer(0, FwdIn, 1'b0, FwdOut, 10, "backpressure_c1");
        xfer(2, FwdIn, 1'b0, FwdOut, 10, "backpressure_c4");

        // Reset while instance 0 is mid-BUSY
        in_valid[0] = 1'b1;
        in_data[0]  = FwdIn;
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("midreset out_valid", 128'(out_valid[k]), 128'd0);
            check("midreset out_data", out_data[k], 128'd0);
            check("midreset busy", 128'(busy[k]), 128'd0);
            check("midreset in_ready", 128'(in_ready[k]), 128'd1);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, FwdIn, 1'b0, FwdOut, 0, "after_reset");

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                x = {$urandom, $urandom, $urandom, $urandom};
                m = 1'($urandom_range(0, 1));
                xfer(k, x, m, model(x, eff(m)), $urandom_range(0, 3), "rand_state");
`ifdef MIXCOL_INV_EN
                xfer(k, model(x, 1'b0), 1'b1, x, $urandom_range(0, 3), "rand_roundtrip");
`else
                xfer(k, model(x, 1'b0), 1'b1, model(model(x, 1'b0), 1'b0),
                     $urandom_range(0, 3), "rand_fwd_twice");
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
